// File: rtl/spi_master_ncs.sv
// SPI master: NUM_CS active-low selects, all CPOL/CPHA modes, SCLK half-period of clk_div+1 clocks; done pulses (2*DATA_W+2)*(clk_div+1) cycles after start.
// start is ignored while busy. Defining SPI_KEEP_CS_EN adds a keep_cs input that holds the chosen select low across transfers.
module spi_master_ncs #(
   parameter int NUM_CS   = 2,
   parameter int DATA_W   = 8,
   parameter int DIV_W    = 8,
   parameter int CS_SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [CS_SEL_W-1:0] cs_sel,
   input  logic                cpol,
   input  logic                cpha,
   input  logic [DIV_W-1:0]    clk_div,
   input  logic [DATA_W-1:0]   tx_data,
`ifdef SPI_KEEP_CS_EN
   input  logic                keep_cs,
`endif
   output logic [DATA_W-1:0]   rx_data,
   output logic                busy,
   output logic                done,
   output logic                sclk,
   output logic                mosi,
   input  logic                miso,
   output logic [NUM_CS-1:0]   cs_n
);
   localparam int EDGES = 2 * DATA_W;
   localparam int EC_W  = $clog2(EDGES + 1);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   state_t              r_state, w_state_nxt;
   logic [DIV_W-1:0]    r_div, r_div_cnt;
   logic [EC_W-1:0]     r_edge_cnt;
   logic [DATA_W-1:0]   r_tx, r_rx, r_rx_data;
   logic [NUM_CS-1:0]   r_cs_n, w_cs_dec;
   logic                r_cpha, r_keep, r_sclk, r_mosi, r_busy, r_done;
   logic                w_tick, w_accept, w_edge, w_lead, w_last_edge;
   logic                w_xfer_end, w_hold_end, w_keep_in;

`ifdef SPI_KEEP_CS_EN
   assign w_keep_in = keep_cs;
`else
   assign w_keep_in = 1'b0;
`endif

   assign w_tick      = (r_div_cnt == r_div);
   assign w_accept    = (r_state == IDLE) && start;
   assign w_xfer_end  = (r_state == XFER) && (r_edge_cnt == EC_W'(EDGES));
   assign w_edge      = w_tick && ((r_state == SETUP) || ((r_state == XFER) && !w_xfer_end));
   assign w_hold_end  = w_tick && (r_state == HOLD);
   assign w_lead      = ~r_edge_cnt[0];
   assign w_last_edge = (r_edge_cnt == EC_W'(EDGES - 1));

   // Out-of-range selects decode to no asserted chip select.
   always_comb begin
      w_cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (cs_sel == CS_SEL_W'(i)) w_cs_dec[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start)      w_state_nxt = SETUP;
         SETUP:   if (w_tick)     w_state_nxt = XFER;
         XFER:    if (w_tick && w_xfer_end) w_state_nxt = HOLD;
         HOLD:    if (w_tick)     w_state_nxt = IDLE;
         default:                 w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div      <= '0;
         r_div_cnt  <= '0;
         r_edge_cnt <= '0;
         r_tx       <= '0;
         r_rx       <= '0;
         r_rx_data  <= '0;
         r_cs_n     <= '1;
         r_cpha     <= 1'b0;
         r_keep     <= 1'b0;
         r_sclk     <= 1'b0;
         r_mosi     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state != IDLE) r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;

         // Latching a new select also drops any select held from a keep_cs transfer.
         if (w_accept) begin
            r_div      <= clk_div;
            r_cpha     <= cpha;
            r_tx       <= tx_data;
            r_keep     <= w_keep_in;
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_busy     <= 1'b1;
            r_sclk     <= cpol;
            r_cs_n     <= w_cs_dec;
            if (!cpha) r_mosi <= tx_data[DATA_W-1];
         end

         // Even edge counts are leading edges; the sampling edge is the one matching cpha.
         if (w_edge) begin
            r_sclk     <= ~r_sclk;
            r_edge_cnt <= r_edge_cnt + 1'b1;
            if (w_lead != r_cpha) begin
               r_rx <= {r_rx[DATA_W-2:0], miso};
            end else if (r_cpha) begin
               r_mosi <= r_tx[DATA_W-1];
               r_tx   <= r_tx << 1;
            end else if (!w_last_edge) begin
               r_mosi <= r_tx[DATA_W-2];
               r_tx   <= r_tx << 1;
            end
         end

         if (w_hold_end) begin
            r_rx_data <= r_rx;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            if (!r_keep) r_cs_n <= '1;
         end
      end
   end

   assign rx_data = r_rx_data;
   assign busy    = r_busy;
   assign done    = r_done;
   assign sclk    = r_sclk;
   assign mosi    = r_mosi;
   assign cs_n    = r_cs_n;
endmodule

// File: tb/tb_spi_master_ncs.sv
// Bench for spi_master_ncs: cycle-level phase model compared every cycle, plus directed literal checks and random transfers.
module tb_spi_master_ncs;
   localparam int NUM_CS = 2;
   localparam int DW     = 8;
   localparam int DIV_W  = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [0:0]        cs_sel = '0;
   logic              cpol = 1'b0;
   logic              cpha = 1'b0;
   logic [DIV_W-1:0]  clk_div = '0;
   logic [DW-1:0]     tx_data = '0;
   logic [DW-1:0]     rx_data;
   logic              busy, done, sclk, mosi, miso;
   logic [NUM_CS-1:0] cs_n;
`ifdef SPI_KEEP_CS_EN
   logic              keep_cs = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int t0 = 0;
   int poke = 0;
   int miso_mode = 0;           // 0 loopback, 1 tied high, 2 slave shifting slave_pat
   logic [DW-1:0] slave_pat = '0;
   logic slave_bit = 1'b0;
   logic slave_arm = 1'b0;
   int s_idx = -1;
   logic s_prev = 1'b0;
   logic prev_sclk = 1'b0;
   logic [DW-1:0] lead_bits = '0;

   spi_master_ncs #(.NUM_CS(NUM_CS), .DATA_W(DW), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
      .clk_div(clk_div), .tx_data(tx_data),
`ifdef SPI_KEEP_CS_EN
      .keep_cs(keep_cs),
`endif
      .rx_data(rx_data), .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 : slave_bit;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave: reacts right after each SCLK change so a wrong sampling edge sees the wrong bit.
   always @(posedge clk) begin
      #1;
      if (slave_arm) begin
         slave_arm = 1'b0;
         s_idx = DW - 1;
         s_prev = sclk;
         if (!cpha) slave_bit = slave_pat[DW-1];
      end else if (sclk !== s_prev) begin
         s_prev = sclk;
         if (sclk !== cpol) begin
            if (cpha && s_idx >= 0) begin
               slave_bit = slave_pat[s_idx];
               s_idx--;
            end
         end else if (!cpha) begin
            s_idx--;
            if (s_idx >= 0) slave_bit = slave_pat[s_idx];
         end
      end
   end

   // Reference model: transfer described as phase index p = cycles_since_start / H.
   logic m_active = 1'b0, m_done = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0, m_keep = 1'b0, m_mosi_idle = 1'b0;
   int m_n = 0, m_h = 1;
   logic [DW-1:0] m_tx = '0, m_rx = '0, m_exp_rx = '0;
   logic [NUM_CS-1:0] m_cs_act = '1, m_cs_idle = '1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0; m_done = 1'b0; m_cpol = 1'b0; m_mosi_idle = 1'b0;
         m_cs_idle = '1; m_rx = '0;
      end else begin
         m_done = 1'b0;
         if (m_active) begin
            m_n++;
            if (m_n == (2 * DW + 2) * m_h) begin
               m_active = 1'b0;
               m_done = 1'b1;
               m_rx = m_exp_rx;
               m_mosi_idle = m_tx[0];
               m_cs_idle = m_keep ? m_cs_act : '1;
            end
         end else if (start) begin
            m_active = 1'b1;
            m_n = 0;
            m_cpol = cpol;
            m_cpha = cpha;
            m_h = int'(clk_div) + 1;
            m_tx = tx_data;
            m_cs_act = '1;
            m_cs_act[cs_sel] = 1'b0;
`ifdef SPI_KEEP_CS_EN
            m_keep = keep_cs;
`else
            m_keep = 1'b0;
`endif
            m_exp_rx = (miso_mode == 0) ? tx_data : (miso_mode == 1) ? '1 : slave_pat;
         end
      end
   end

   always @(posedge clk) begin
      int p;
      logic e_sclk, e_mosi;
      logic [NUM_CS-1:0] e_cs;
      #1;
      if (rst_n) begin
         if (m_active) begin
            p = m_n / m_h;
            e_sclk = m_cpol ^ ((p >= 1 && p <= 2 * DW) ? p[0] : 1'b0);
            e_cs = m_cs_act;
            if (!m_cpha) e_mosi = m_tx[DW - 1 - ((p < 2 * DW - 1 ? p : 2 * DW - 1) / 2)];
            else if (p == 0) e_mosi = m_mosi_idle;
            else e_mosi = m_tx[DW - 1 - (((p < 2 * DW ? p : 2 * DW)) - 1) / 2];
         end else begin
            e_sclk = m_cpol;
            e_cs = m_cs_idle;
            e_mosi = m_mosi_idle;
         end
         chk("sclk", sclk, e_sclk);
         chk("mosi", mosi, e_mosi);
         chk("cs_n", cs_n, e_cs);
         chk("busy", busy, m_active);
         chk("done", done, m_done);
         chk("rx_data", rx_data, m_rx);
         if (busy && sclk !== prev_sclk && sclk !== cpol) lead_bits = {lead_bits[DW-2:0], mosi};
         prev_sclk = sclk;
      end
   end

   task automatic launch(input logic sel, input logic pol, input logic pha, input int div,
                         input logic [DW-1:0] tx, input int mode, input logic [DW-1:0] pat, input logic keep);
      @(negedge clk);
      cs_sel = sel; cpol = pol; cpha = pha; clk_div = DIV_W'(div); tx_data = tx;
      miso_mode = mode; slave_pat = pat; lead_bits = '0;
      if (mode == 2) slave_arm = 1'b1;
`ifdef SPI_KEEP_CS_EN
      keep_cs = keep;
`else
      if (keep) $display("keep_cs not built in");
`endif
      start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 1; k <= 2000; k++) begin
         @(posedge clk);
         #1;
         if (poke > 0 && k == poke - 1) begin
            start = 1'b1;
            tx_data = 8'hFF;
         end else if (poke > 0 && k == poke) begin
            start = 1'b0;
         end
         if (done) begin
            lat = cyc - t0;
            break;
         end
      end
      n_checks++;
      if (lat < 0) begin
         n_errors++;
         $display("FAIL done_timeout: got no done expected done within 2000 cycles");
      end
   endtask

   initial begin
      int lat;
      logic [DW-1:0] exp;
      #3 rst_n = 1'b0;
      #1;
      chk("rst_sclk", sclk, 1'b0);
      chk("rst_mosi", mosi, 1'b0);
      chk("rst_cs_n", cs_n, 2'b11);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rx", rx_data, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Mode 0, loopback
      launch(1'b0, 1'b0, 1'b0, 0, 8'hA5, 0, 8'h00, 1'b0);
      chk("m0_cs_active", cs_n, 2'b10);
      chk("m0_busy", busy, 1'b1);
      wait_done(lat);
      chk("m0_latency", lat, 18);
      chk("m0_rx", rx_data, 8'hA5);
      chk("m0_busy_at_done", busy, 1'b0);
      @(posedge clk); #1;
      chk("m0_sclk_idle", sclk, 1'b0);

      // Mode 3, miso tied high
      launch(1'b0, 1'b1, 1'b1, 3, 8'h3C, 1, 8'h00, 1'b0);
      wait_done(lat);
      chk("m3_latency", lat, 72);
      chk("m3_rx", rx_data, 8'hFF);
      chk("m3_lead_mosi", lead_bits, 8'h3C);
      @(posedge clk); #1;
      chk("m3_sclk_idle", sclk, 1'b1);

      // Modes 1 and 2 against a shifting slave
      launch(1'b1, 1'b0, 1'b1, 1, 8'hC3, 2, 8'h5A, 1'b0);
      chk("m1_cs_active", cs_n, 2'b01);
      wait_done(lat);
      chk("m1_rx", rx_data, 8'h5A);
      launch(1'b0, 1'b1, 1'b0, 2, 8'h0F, 2, 8'h5A, 1'b0);
      wait_done(lat);
      chk("m2_rx", rx_data, 8'h5A);

      // start while busy is ignored
      poke = 5;
      launch(1'b0, 1'b0, 1'b0, 0, 8'h12, 0, 8'h00, 1'b0);
      wait_done(lat);
      poke = 0;
      chk("busy_ign_latency", lat, 18);
      chk("busy_ign_rx", rx_data, 8'h12);

      // back-to-back start in the done cycle
      launch(1'b0, 1'b0, 1'b0, 0, 8'h33, 0, 8'h00, 1'b0);
      wait_done(lat);
      chk("b2b_gap", cs_n, 2'b11);
      start = 1'b1;
      tx_data = 8'hC3;
      @(posedge clk); #1;
      t0 = cyc;
      start = 1'b0;
      chk("b2b_cs_active", cs_n, 2'b10);
      wait_done(lat);
      chk("b2b_latency", lat, 18);
      chk("b2b_rx", rx_data, 8'hC3);

      // Mid-transfer reset after a transfer that leaves rx_data at zero
      launch(1'b0, 1'b0, 1'b0, 0, 8'h00, 0, 8'h00, 1'b0);
      wait_done(lat);
      launch(1'b0, 1'b1, 1'b1, 3, 8'h96, 1, 8'h00, 1'b0);
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_cs_n", cs_n, 2'b11);
      chk("abort_sclk", sclk, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_rx", rx_data, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef SPI_KEEP_CS_EN
      launch(1'b1, 1'b0, 1'b0, 0, 8'h11, 0, 8'h00, 1'b1);
      wait_done(lat);
      @(posedge clk); #1;
      chk("keep_hold", cs_n, 2'b01);
      launch(1'b1, 1'b0, 1'b0, 0, 8'h22, 0, 8'h00, 1'b0);
      wait_done(lat);
      chk("keep_release_done", cs_n, 2'b11);
      launch(1'b1, 1'b0, 1'b0, 0, 8'h44, 0, 8'h00, 1'b1);
      wait_done(lat);
      launch(1'b0, 1'b0, 1'b0, 0, 8'h55, 0, 8'h00, 1'b0);
      chk("keep_release_switch", cs_n, 2'b10);
      wait_done(lat);
`endif

      // Randomised transfers
      for (int i = 0; i < 24; i++) begin
         logic rs, rp, rh, rk;
         int rd, rm;
         logic [DW-1:0] rt, rpat;
         rs = 1'($urandom_range(0, 1));
         rp = 1'($urandom_range(0, 1));
         rh = 1'($urandom_range(0, 1));
         rk = 1'($urandom_range(0, 1));
         rd = $urandom_range(0, 3);
         rm = $urandom_range(0, 2);
         rt = DW'($urandom);
         rpat = DW'($urandom);
`ifndef SPI_KEEP_CS_EN
         rk = 1'b0;
`endif
         launch(rs, rp, rh, rd, rt, rm, rpat, rk);
         wait_done(lat);
         chk("rand_latency", lat, (2 * DW + 2) * (rd + 1));
         exp = (rm == 0) ? rt : (rm == 1) ? 8'hFF : rpat;
         chk("rand_rx", rx_data, exp);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
